// File: rtl/arc4_pkg.sv
// Shared types and helpers for the RC4 key-scheduling engine.
package arc4_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      RD_I,
      GET_I,
      RD_J,
      WR_J,
      WR_I,
      DONE
   } ksa_state_t;

   // Symbol/address width for an S-box of depth n.
   function automatic int unsigned sym_width(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/arc4_ksa_engine_if.sv
// Start handshake plus single-port S memory bus between the KSA engine and its surroundings.
interface arc4_ksa_engine_if #(
   parameter int unsigned N         = 256,
   parameter int unsigned KEY_BYTES = 3
);
   localparam int unsigned SYM_W = arc4_pkg::sym_width(N);

   logic                       en;
   logic                       rdy;
   logic [KEY_BYTES*SYM_W-1:0] key;
   logic [SYM_W-1:0]           addr;
   logic [SYM_W-1:0]           wrdata;
   logic                       wren;
   logic [SYM_W-1:0]           rddata;

   modport master (
      input  en, key, rddata,
      output rdy, addr, wrdata, wren
   );

   modport slave (
      output en, key, rddata,
      input  rdy, addr, wrdata, wren
   );
endinterface

// File: rtl/arc4_key_sel.sv
// Selects key symbol idx from a packed key vector; symbol 0 sits in the most significant bits.
module arc4_key_sel #(
   parameter int unsigned KEY_BYTES = 3,
   parameter int unsigned SYM_W     = 8,
   parameter int unsigned IDX_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
   input  logic [KEY_BYTES*SYM_W-1:0] key,
   input  logic [IDX_W-1:0]           idx,
   output logic [SYM_W-1:0]           sym_c
);

   always_comb begin
      sym_c = '0;
      for (int b = 0; b < KEY_BYTES; b++) begin
         if (idx == IDX_W'(b)) begin
            sym_c = key[(KEY_BYTES-1-b)*SYM_W +: SYM_W];
         end
      end
   end

endmodule

// File: rtl/arc4_ksa_engine.sv
// RC4 key-scheduling engine: optional S-box fill, then the KSA swap loop over an
// external single-port S memory with one-cycle read latency.
module arc4_ksa_engine
   import arc4_pkg::*;
#(
   parameter int unsigned N          = 256,
   parameter int unsigned SYM_W      = sym_width(N),
   parameter int unsigned KEY_BYTES  = 3,
   parameter int unsigned INIT_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,
   arc4_ksa_engine_if.master bus
);

   localparam int unsigned KEY_W  = KEY_BYTES * SYM_W;
   localparam int unsigned KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [SYM_W-1:0]  LAST_I = SYM_W'(N - 1);
   localparam logic [KIDX_W-1:0] LAST_K = KIDX_W'(KEY_BYTES - 1);

   ksa_state_t        state;
   logic [SYM_W-1:0]  i;
   logic [SYM_W-1:0]  j;
   logic [SYM_W-1:0]  si;
   logic [KIDX_W-1:0] kidx;
   logic [KEY_W-1:0]  key_q;
   logic              rdy_q;
   logic [SYM_W-1:0]  addr_q;
   logic [SYM_W-1:0]  wrdata_q;
   logic              wren_q;

   logic [SYM_W-1:0]  k_c;
   logic [SYM_W-1:0]  j_next_c;

   arc4_key_sel #(
      .KEY_BYTES (KEY_BYTES),
      .SYM_W     (SYM_W),
      .IDX_W     (KIDX_W)
   ) u_key_sel (
      .key   (key_q),
      .idx   (kidx),
      .sym_c (k_c)
   );

   // Sum wraps naturally at SYM_W bits, i.e. mod N.
   assign j_next_c = j + bus.rddata + k_c;

   assign bus.rdy    = rdy_q;
   assign bus.addr   = addr_q;
   assign bus.wrdata = wrdata_q;
   assign bus.wren   = wren_q;

   // Outputs are loaded on entry to each state so they line up with that state's cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         i        <= '0;
         j        <= '0;
         si       <= '0;
         kidx     <= '0;
         key_q    <= '0;
         rdy_q    <= 1'b1;
         addr_q   <= '0;
         wrdata_q <= '0;
         wren_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wren_q <= 1'b0;
               if (bus.en) begin
                  key_q    <= bus.key;
                  i        <= '0;
                  j        <= '0;
                  kidx     <= '0;
                  rdy_q    <= 1'b0;
                  addr_q   <= '0;
                  wrdata_q <= '0;
                  if (INIT_FIRST != 0) begin
                     state  <= FILL;
                     wren_q <= 1'b1;
                  end else begin
                     state  <= RD_I;
                  end
               end
            end

            FILL: begin
               if (i == LAST_I) begin
                  i      <= '0;
                  addr_q <= '0;
                  wren_q <= 1'b0;
                  state  <= RD_I;
               end else begin
                  i        <= i + SYM_W'(1);
                  addr_q   <= i + SYM_W'(1);
                  wrdata_q <= i + SYM_W'(1);
                  wren_q   <= 1'b1;
               end
            end

            RD_I: begin
               state <= GET_I;
            end

            GET_I: begin
               si     <= bus.rddata;
               j      <= j_next_c;
               addr_q <= j_next_c;
               state  <= RD_J;
            end

            RD_J: begin
               wrdata_q <= si;
               wren_q   <= 1'b1;
               state    <= WR_J;
            end

            // rddata now holds s[j]; it goes straight out as the WR_I write data.
            WR_J: begin
               addr_q   <= i;
               wrdata_q <= bus.rddata;
               wren_q   <= 1'b1;
               state    <= WR_I;
            end

            WR_I: begin
               wren_q <= 1'b0;
               if (i == LAST_I) begin
                  state <= DONE;
               end else begin
                  i      <= i + SYM_W'(1);
                  addr_q <= i + SYM_W'(1);
                  kidx   <= (kidx == LAST_K) ? '0 : kidx + KIDX_W'(1);
                  state  <= RD_I;
               end
            end

            DONE: begin
               wren_q <= 1'b0;
               rdy_q  <= 1'b1;
               state  <= IDLE;
            end

            default: begin
               state  <= IDLE;
               rdy_q  <= 1'b1;
               wren_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arc4_ksa_engine.sv
// Directed bench for arc4_ksa_engine: a 256-entry/3-byte-key instance and a 16-entry/2-byte-key instance.
module tb_arc4_ksa_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   arc4_ksa_engine_if #(.N(256), .KEY_BYTES(3)) ifa ();
   arc4_ksa_engine_if #(.N(16),  .KEY_BYTES(2)) ifb ();

   arc4_ksa_engine #(.N(256), .KEY_BYTES(3), .INIT_FIRST(1)) dut_a (
      .clk (clk), .rst (rst), .bus (ifa)
   );
   arc4_ksa_engine #(.N(16), .KEY_BYTES(2), .INIT_FIRST(1)) dut_b (
      .clk (clk), .rst (rst), .bus (ifb)
   );

   logic [7:0] mem_a [256];
   logic [3:0] mem_b [16];
   int         wa_addr [$];
   int         wa_data [$];
   int         max_b = 0;
   int         model [256];
   int         kk [32];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Synchronous S memories with one-cycle read latency.
   always @(posedge clk) begin
      if (ifa.wren) begin
         mem_a[ifa.addr] <= ifa.wrdata;
         wa_addr.push_back(int'(ifa.addr));
         wa_data.push_back(int'(ifa.wrdata));
      end
      ifa.rddata <= mem_a[ifa.addr];
   end

   always @(posedge clk) begin
      if (ifb.wren) mem_b[ifb.addr] <= ifb.wrdata;
      if (!ifb.rdy && int'(ifb.addr) > max_b) max_b <= int'(ifb.addr);
      ifb.rddata <= mem_b[ifb.addr];
   end

   // Plain textbook KSA over kk[], for comparison with the DUT's final S.
   task automatic run_model(input int n, input int kb);
      int jm, t;
      for (int x = 0; x < n; x++) model[x] = x;
      jm = 0;
      for (int x = 0; x < n; x++) begin
         jm = (jm + model[x] + kk[x % kb]) % n;
         t = model[x]; model[x] = model[jm]; model[jm] = t;
      end
   endtask

   function automatic int diff_a();
      int d = 0;
      for (int x = 0; x < 256; x++) if (int'(mem_a[x]) != model[x]) d++;
      return d;
   endfunction

   function automatic int diff_b();
      int d = 0;
      for (int x = 0; x < 16; x++) if (int'(mem_b[x]) != model[x]) d++;
      return d;
   endfunction

   task automatic set_model_key_a(input logic [23:0] kv);
      kk[0] = int'(kv[23:16]);
      kk[1] = int'(kv[15:8]);
      kk[2] = int'(kv[7:0]);
      run_model(256, 3);
   endtask

   // Counts negedges with rdy low, starting at the current negedge.
   task automatic wait_a(input bit abuse, output int cnt);
      cnt = 0;
      while (!ifa.rdy && cnt < 4000) begin
         cnt++;
         if (abuse && cnt == 100) begin
            ifa.en  = 1'b1;
            ifa.key = 24'hFFFFFF;
         end
         if (abuse && cnt == 101) ifa.en = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic start_a(input logic [23:0] kv, input bit hold);
      @(negedge clk);
      ifa.key = kv;
      ifa.en  = 1'b1;
      @(negedge clk);
      if (!hold) ifa.en = 1'b0;
   endtask

   initial begin
      int cnt, bad;
      ifa.en = 1'b0; ifa.key = '0;
      ifb.en = 1'b0; ifb.key = '0;

      // Reset and idle behaviour.
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_rdy_a",  int'(ifa.rdy),  1);
      check("rst_wren_a", int'(ifa.wren), 0);
      check("rst_addr_a", int'(ifa.addr), 0);
      check("rst_rdy_b",  int'(ifb.rdy),  1);
      check("rst_wren_b", int'(ifb.wren), 0);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (ifa.wren || ifb.wren || !ifa.rdy || !ifb.rdy) bad++;
      end
      check("idle_quiet", bad, 0);

      // Small configuration, key symbols 0xA, 0x5.
      @(negedge clk);
      ifb.key = 8'hA5;
      ifb.en  = 1'b1;
      @(negedge clk);
      ifb.en  = 1'b0;
      cnt = 0;
      while (!ifb.rdy && cnt < 500) begin
         cnt++;
         @(negedge clk);
      end
      check("small_rdy_low", cnt, 97);
      kk[0] = 10; kk[1] = 5;
      run_model(16, 2);
      check("small_final_s", diff_b(), 0);
      check("small_max_addr", max_b, 15);

      // Main configuration, key 00 03 3C.
      wa_addr.delete(); wa_data.delete();
      start_a(24'h00033C, 1'b0);
      wait_a(1'b0, cnt);
      check("big_rdy_low", cnt, 1537);
      check("big_write_count", wa_addr.size(), 768);
      bad = 0;
      for (int x = 0; x < 256; x++)
         if (x >= wa_addr.size() || wa_addr[x] != x || wa_data[x] != x) bad++;
      check("fill_writes", bad, 0);
      if (wa_addr.size() >= 262) begin
         check("it0_wrj_addr", wa_addr[256], 0);
         check("it0_wrj_data", wa_data[256], 0);
         check("it0_wri_addr", wa_addr[257], 0);
         check("it0_wri_data", wa_data[257], 0);
         check("it1_wrj_addr", wa_addr[258], 4);
         check("it1_wrj_data", wa_data[258], 1);
         check("it1_wri_addr", wa_addr[259], 1);
         check("it1_wri_data", wa_data[259], 4);
         check("it2_wrj_addr", wa_addr[260], 66);
         check("it2_wrj_data", wa_data[260], 2);
         check("it2_wri_addr", wa_addr[261], 2);
         check("it2_wri_data", wa_data[261], 66);
      end else begin
         check("early_writes_present", wa_addr.size(), 768);
      end
      set_model_key_a(24'h00033C);
      check("big_final_s", diff_a(), 0);

      // en and key disturbed mid-run must be ignored.
      start_a(24'h00033C, 1'b0);
      wait_a(1'b1, cnt);
      check("abuse_rdy_low", cnt, 1537);
      check("abuse_final_s", diff_a(), 0);

      // en held high: a new run begins right as rdy returns.
      start_a(24'h123456, 1'b1);
      wait_a(1'b0, cnt);
      check("held_rdy_low", cnt, 1537);
      check("held_rdy_pulse", int'(ifa.rdy), 1);
      @(negedge clk);
      check("held_restart", int'(ifa.rdy), 0);
      ifa.en = 1'b0;
      wait_a(1'b0, cnt);
      check("held_second_low", cnt, 1537);
      set_model_key_a(24'h123456);
      check("held_final_s", diff_a(), 0);

      // Reset while the KSA is around i=100.
      wa_addr.delete(); wa_data.delete();
      start_a(24'h00033C, 1'b0);
      cnt = 0;
      while (wa_addr.size() < 456 && cnt < 3000) begin
         cnt++;
         @(negedge clk);
      end
      check("reached_i100", int'(wa_addr.size() >= 456), 1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_rdy",  int'(ifa.rdy),  1);
      check("midrst_wren", int'(ifa.wren), 0);
      check("midrst_addr", int'(ifa.addr), 0);
      rst = 1'b0;
      start_a(24'h0A0B0C, 1'b0);
      wait_a(1'b0, cnt);
      check("post_rst_rdy_low", cnt, 1537);
      set_model_key_a(24'h0A0B0C);
      check("post_rst_final_s", diff_a(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
